mem_access: RTL and testbench

Memory-access stage of the five-stage core, sitting between the EX/MEM pipeline register and MEM_WB. It issues loads and stores to the data-side SRAM-style request bus, which the AXI-Lite bridge services. It aligns and sign/zero-extends load data and holds the pipeline until the access completes. Non-memory instructions pass their register write-back straight through to MEM_WB.

---
 rtl/mem_access.sv | 155 +++++++++++++++
 tb/tb_mem_access.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores on the data request bus,
// extends load data and stalls the pipeline until the access completes.
module mem_access #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     ex_write_data,
    input  logic [REG_ADDR_W-1:0] ex_write_addr,
    input  logic                  ex_write_en,
    input  logic [3:0]            ex_mem_op,
    input  logic [DATA_W-1:0]     ex_mem_addr,
    input  logic [DATA_W-1:0]     ex_store_data,
    output logic [DATA_W-1:0]     mem_write_data,
    output logic [REG_ADDR_W-1:0] mem_write_addr,
    output logic                  mem_write_en,
    output logic                  stall_req,
    output logic                  mem_addr_err,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [DATA_W-1:0]     data_addr,
    output logic [DATA_W-1:0]     data_wdata,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [DATA_W-1:0]     data_rdata,
    output logic [1:0]            dbg_state
);

    // Bus handshake: data_req stays high in REQ until data_addr_ok is sampled
    // at a rising edge; the response is then the first data_data_ok sampled in WAIT.
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t state, state_nxt;

    logic              is_load, is_store, is_mem, misaligned, op_ok, dec_sign;
    logic [1:0]        dec_size;
    logic [DATA_W-1:0] lane_data;

    logic              wr_r, sign_r;
    logic [1:0]        size_r;
    logic [DATA_W-1:0] addr_r, wdata_r, rdata_r;

    logic [DATA_W-1:0] byte_sh, half_sh, load_val;

    always_comb begin
        is_load  = (ex_mem_op >= 4'h1) && (ex_mem_op <= 4'h5);
        is_store = (ex_mem_op >= 4'h9) && (ex_mem_op <= 4'hB);
        is_mem   = is_load || is_store;
        dec_sign = (ex_mem_op == 4'h1) || (ex_mem_op == 4'h3);
        case (ex_mem_op)
            4'h3, 4'h4, 4'hA: dec_size = 2'd1;
            4'h5, 4'hB:       dec_size = 2'd2;
            default:          dec_size = 2'd0;
        endcase
        misaligned = is_mem && (((dec_size == 2'd1) && ex_mem_addr[0]) ||
                                ((dec_size == 2'd2) && (ex_mem_addr[1:0] != 2'b00)));
        op_ok = is_mem && !misaligned;
        case (dec_size)
            2'd0:    lane_data = {(DATA_W/8){ex_store_data[7:0]}};
            2'd1:    lane_data = {(DATA_W/16){ex_store_data[15:0]}};
            default: lane_data = ex_store_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            wr_r    <= 1'b0;
            sign_r  <= 1'b0;
            size_r  <= 2'd0;
            addr_r  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && op_ok) begin
                wr_r    <= is_store;
                sign_r  <= dec_sign;
                size_r  <= dec_size;
                addr_r  <= ex_mem_addr;
                wdata_r <= lane_data;
            end
            if (state == S_WAIT && data_data_ok)
                rdata_r <= data_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (op_ok) state_nxt = S_REQ;
            S_REQ:   if (data_addr_ok) state_nxt = S_WAIT;
            S_WAIT:  if (data_data_ok) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Little-endian lane select from the captured word.
    always_comb begin
        byte_sh = rdata_r >> {addr_r[1:0], 3'b000};
        half_sh = rdata_r >> {addr_r[1], 4'b0000};
        case (size_r)
            2'd0:    load_val = sign_r ? {{(DATA_W-8){byte_sh[7]}}, byte_sh[7:0]}
                                       : {{(DATA_W-8){1'b0}}, byte_sh[7:0]};
            2'd1:    load_val = sign_r ? {{(DATA_W-16){half_sh[15]}}, half_sh[15:0]}
                                       : {{(DATA_W-16){1'b0}}, half_sh[15:0]};
            default: load_val = rdata_r;
        endcase
    end

    always_comb begin
        mem_write_data = '0;
        mem_write_addr = '0;
        mem_write_en   = 1'b0;
        stall_req      = 1'b0;
        mem_addr_err   = 1'b0;
        data_req       = 1'b0;
        data_wr        = 1'b0;
        data_size      = 2'd0;
        data_addr      = '0;
        data_wdata     = '0;
        dbg_state      = 2'd0;
        if (!rst) begin
            dbg_state  = state;
            data_wr    = wr_r;
            data_size  = size_r;
            data_addr  = addr_r;
            data_wdata = wdata_r;
            case (state)
                S_IDLE: begin
                    mem_addr_err   = misaligned;
                    stall_req      = op_ok;
                    mem_write_data = ex_write_data;
                    mem_write_addr = ex_write_addr;
                    mem_write_en   = ex_write_en && !is_mem;
                end
                S_REQ: begin
                    data_req  = 1'b1;
                    stall_req = 1'b1;
                end
                S_WAIT: stall_req = 1'b1;
                default: begin
                    if (!wr_r) begin
                        mem_write_data = load_val;
                        mem_write_addr = ex_write_addr;
                        mem_write_en   = ex_write_en;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads, stores, misalignment
// and reset in the middle of a transaction.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ex_write_data = '0;
    logic [4:0]  ex_write_addr = '0;
    logic        ex_write_en = 1'b0;
    logic [3:0]  ex_mem_op = '0;
    logic [31:0] ex_mem_addr = '0;
    logic [31:0] ex_store_data = '0;
    logic [31:0] mem_write_data;
    logic [4:0]  mem_write_addr;
    logic        mem_write_en;
    logic        stall_req;
    logic        mem_addr_err;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    mem_access dut (
        .clk(clk), .rst(rst),
        .ex_write_data(ex_write_data), .ex_write_addr(ex_write_addr),
        .ex_write_en(ex_write_en), .ex_mem_op(ex_mem_op),
        .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
        .mem_write_data(mem_write_data), .mem_write_addr(mem_write_addr),
        .mem_write_en(mem_write_en), .stall_req(stall_req),
        .mem_addr_err(mem_addr_err), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] wdata, input logic [4:0] waddr, input logic wen);
        ex_mem_op     = op;
        ex_mem_addr   = addr;
        ex_store_data = sdata;
        ex_write_data = wdata;
        ex_write_addr = waddr;
        ex_write_en   = wen;
    endtask

    // Runs one memory op from IDLE; bus responder accepts after ad extra REQ
    // cycles and answers after dd extra WAIT cycles.
    task automatic do_access(input string tag, input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [31:0] rdata,
                             input logic [4:0] wa, input int ad, input int dd,
                             input logic exp_wr, input logic [1:0] exp_size,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_res,
                             input logic exp_en);
        int  phase = 0;
        int  req_seen = 0;
        int  wcnt = 0;
        int  stalls = 0;
        bit  done = 1'b0;
        set_ex(op, addr, sdata, 32'h5A5A_5A5A, wa, 1'b1);
        data_rdata = rdata;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (stall_req) stalls++;
            case (phase)
                0: if (data_req) begin
                    if (req_seen == 0) begin
                        chk({tag, " data_wr"}, 32'(data_wr), 32'(exp_wr));
                        chk({tag, " data_size"}, 32'(data_size), 32'(exp_size));
                        chk({tag, " data_addr"}, data_addr, addr);
                        if (exp_wr) chk({tag, " data_wdata"}, data_wdata, exp_wdata);
                    end
                    req_seen++;
                    if (req_seen > ad) begin
                        data_addr_ok = 1'b1;
                        phase = 1;
                    end
                end
                1: begin
                    data_addr_ok = 1'b0;
                    if (wcnt == 0) chk({tag, " req low in wait"}, 32'(data_req), 32'd0);
                    if (wcnt >= dd) begin
                        data_data_ok = 1'b1;
                        phase = 2;
                    end
                    wcnt++;
                end
                default: begin
                    data_data_ok = 1'b0;
                    chk({tag, " done state"}, 32'(dbg_state), 32'd3);
                    chk({tag, " done stall"}, 32'(stall_req), 32'd0);
                    chk({tag, " done en"}, 32'(mem_write_en), 32'(exp_en));
                    if (exp_en) begin
                        chk({tag, " result"}, mem_write_data, exp_res);
                        chk({tag, " wb addr"}, 32'(mem_write_addr), 32'(wa));
                    end
                    done = 1'b1;
                end
            endcase
        end
        if (!done) chk({tag, " timeout"}, 32'd0, 32'd1);
        chk({tag, " stall cycles"}, 32'(stalls), 32'(3 + ad + dd));
        @(posedge clk);
        #1;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        set_ex(4'h0, '0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        // Outputs held at zero while reset is asserted, even with live inputs.
        set_ex(4'h0, 32'h0, 32'h0, 32'h1234, 5'd3, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst wdata", mem_write_data, 32'h0);
        chk("rst wen", 32'(mem_write_en), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("reset state", 32'(dbg_state), 32'd0);
        chk("alu data", mem_write_data, 32'h1234);
        chk("alu addr", 32'(mem_write_addr), 32'd3);
        chk("alu en", 32'(mem_write_en), 32'd1);
        chk("alu stall", 32'(stall_req), 32'd0);
        chk("alu req", 32'(data_req), 32'd0);

        set_ex(4'h6, 32'h1000, 32'h0, 32'hCAFE, 5'd9, 1'b1);
        #1;
        chk("undef op data", mem_write_data, 32'hCAFE);
        chk("undef op en", 32'(mem_write_en), 32'd1);
        chk("undef op stall", 32'(stall_req), 32'd0);
        @(posedge clk);
        #1 set_ex(4'h0, '0, '0, '0, '0, 1'b0);

        do_access("LB late", 4'h1, 32'h1001, 32'h0, 32'h80FF_7F00, 5'd4, 1, 1,
                  1'b0, 2'd0, 32'h0, 32'h0000_007F, 1'b1);
        do_access("LB min", 4'h1, 32'h1003, 32'h0, 32'h80FF_7F00, 5'd5, 0, 0,
                  1'b0, 2'd0, 32'h0, 32'hFFFF_FF80, 1'b1);
        do_access("LBU", 4'h2, 32'h1003, 32'h0, 32'h80FF_7F00, 5'd6, 0, 2,
                  1'b0, 2'd0, 32'h0, 32'h0000_0080, 1'b1);
        do_access("LHU", 4'h4, 32'h1002, 32'h0, 32'h8001_1234, 5'd7, 0, 0,
                  1'b0, 2'd1, 32'h0, 32'h0000_8001, 1'b1);
        do_access("LH hi", 4'h3, 32'h1002, 32'h0, 32'h8001_1234, 5'd8, 2, 0,
                  1'b0, 2'd1, 32'h0, 32'hFFFF_8001, 1'b1);
        do_access("LH lo", 4'h3, 32'h1000, 32'h0, 32'h8001_1234, 5'd10, 0, 0,
                  1'b0, 2'd1, 32'h0, 32'h0000_1234, 1'b1);
        do_access("SB", 4'h9, 32'h2003, 32'h0000_00AB, 32'h0, 5'd11, 0, 0,
                  1'b1, 2'd0, 32'hABAB_ABAB, 32'h0, 1'b0);
        do_access("SH", 4'hA, 32'h2002, 32'h1234_CDEF, 32'h0, 5'd12, 1, 0,
                  1'b1, 2'd1, 32'hCDEF_CDEF, 32'h0, 1'b0);
        do_access("SW", 4'hB, 32'h2000, 32'hDEAD_BEEF, 32'h0, 5'd13, 0, 1,
                  1'b1, 2'd2, 32'hDEAD_BEEF, 32'h0, 1'b0);

        // Misaligned word and halfword: flagged, no bus traffic, no stall.
        set_ex(4'h5, 32'h2002, 32'h0, 32'h0, 5'd14, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("LW misaligned err", 32'(mem_addr_err), 32'd1);
            chk("LW misaligned req", 32'(data_req), 32'd0);
            chk("LW misaligned stall", 32'(stall_req), 32'd0);
            chk("LW misaligned en", 32'(mem_write_en), 32'd0);
        end
        set_ex(4'h3, 32'h2001, 32'h0, 32'h0, 5'd14, 1'b1);
        @(negedge clk);
        chk("LH misaligned err", 32'(mem_addr_err), 32'd1);
        chk("LH misaligned stall", 32'(stall_req), 32'd0);
        @(posedge clk);
        #1 set_ex(4'h0, '0, '0, '0, '0, 1'b0);
        @(negedge clk);
        chk("aligned err clear", 32'(mem_addr_err), 32'd0);

        // Reset while waiting for the response; a late data_ok must be ignored.
        @(posedge clk);
        #1 set_ex(4'h5, 32'h3000, 32'h0, 32'h0, 5'd15, 1'b1);
        data_rdata = 32'h1111_2222;
        @(negedge clk);
        @(negedge clk);
        chk("rst-wait req", 32'(data_req), 32'd1);
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        chk("rst-wait state", 32'(dbg_state), 32'd2);
        rst = 1'b1;
        #1;
        chk("rst-wait stall forced", 32'(stall_req), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_ex(4'h0, '0, '0, '0, '0, 1'b0);
        data_data_ok = 1'b1;
        @(negedge clk);
        chk("post-rst state", 32'(dbg_state), 32'd0);
        chk("post-rst stall", 32'(stall_req), 32'd0);
        chk("post-rst req", 32'(data_req), 32'd0);
        chk("post-rst wen", 32'(mem_write_en), 32'd0);
        chk("post-rst data", mem_write_data, 32'h0);
        chk("post-rst addr", data_addr, 32'h0);
        chk("post-rst wr", 32'(data_wr), 32'd0);
        @(posedge clk);
        #1 data_data_ok = 1'b0;
        @(negedge clk);
        chk("late data_ok ignored", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
        do_access("LW after rst", 4'h5, 32'h3000, 32'h0, 32'h1234_5678, 5'd16, 0, 0,
                  1'b0, 2'd2, 32'h0, 32'h1234_5678, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
